booth_seq_mult: RTL

Iterative signed radix-2 Booth multiplier that reuses a single add/subtract-and-shift step over WIDTH clock cycles. It replaces the fully unrolled combinational Booth array where area matters more than throughput. It sits between a producer and a consumer with valid/ready handshakes on both sides, and processes one operand pair at a time.

---
 rtl/booth_pkg.sv | 9 +
 rtl/booth_step.sv | 24 ++
 rtl/booth_seq_mult.sv | 77 +++++++
 3 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared width default, FSM state encoding and Booth op decode
package booth_pkg;
  localparam int WIDTH_DEF = 16;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_e;
  function automatic booth_op_e booth_op(input logic [1:0] pair);
    return pair == 2'b01 ? ADD : pair == 2'b10 ? SUB : NOP;
  endfunction
endpackage

// File: rtl/booth_step.sv
// booth_step: one radix-2 Booth add/sub then arithmetic right shift (acc_i/q_i/qm1_i/a_i -> acc_o/q_o/qm1_o)
module booth_step import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             qm1_i,
  input  logic [WIDTH-1:0] a_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] q_o,
  output logic             qm1_o
);
  booth_op_e op;
  logic [WIDTH:0] ax;
  logic [WIDTH:0] sum;
  always_comb begin
    op  = booth_op({q_i[0], qm1_i});
    ax  = {a_i[WIDTH-1], a_i};
    sum = op == ADD ? acc_i + ax : op == SUB ? acc_i + ~ax + (WIDTH+1)'(1) : acc_i;
  end
  assign acc_o = {sum[WIDTH], sum[WIDTH:1]};
  assign q_o   = {sum[0], q_i[WIDTH-1:1]};
  assign qm1_o = q_i[0];
endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential signed Booth multiplier; in_valid/in_ready/a/b in, out_valid/out_ready/p out, busy
module booth_seq_mult import booth_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [WIDTH:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d, a_q;
  logic qm1_q, qm1_d;
  logic [2*WIDTH-1:0] p_q;
  logic out_valid_q;
  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc_i(acc_q),
    .q_i  (q_q),
    .qm1_i(qm1_q),
    .a_i  (a_q),
    .acc_o(acc_d),
    .q_o  (q_d),
    .qm1_o(qm1_d)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      qm1_q       <= 1'b0;
      a_q         <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          a_q     <= a;
          acc_q   <= '0;
          q_q     <= b;
          qm1_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= qm1_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            p_q         <= {acc_d[WIDTH-1:0], q_d};
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign in_ready  = state_q == IDLE;
  assign busy      = state_q != IDLE;
  assign out_valid = out_valid_q;
  assign p         = p_q;
endmodule
